twiddle_mult_radix2: RTL and testbench

Consumer side of the 16-point radix-2 twiddle ROM. The block accepts lower-leg butterfly samples in order. It generates the ROM address from internal stage and butterfly counters, captures the returned Q15 twiddle, and produces the pipelined, rounded, saturated complex product for the butterfly datapath. It sits between the butterfly subtract output and the inter-stage buffer, and hides twiddle sequencing from the FFT controller.

---
 rtl/fft_radix2_pkg.sv | 22 ++
 rtl/twiddle_addr_gen.sv | 47 ++++
 rtl/twiddle_mult_radix2.sv | 119 +++++++++++
 tb/tb_twiddle_mult_radix2.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_radix2_pkg.sv
// Shared constants and types for the 16-point radix-2 FFT datapath.
package fft_radix2_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int N_POINTS  = 16;
    localparam int LOG2N     = 4;
    localparam int N_BFLY    = 8;
    localparam int Q_FRAC    = WIDTH_DEF - 1;
    localparam int STAGE_W   = 2;
    localparam int IDX_W     = 3;

    typedef logic [STAGE_W-1:0] stage_t;
    typedef logic [IDX_W-1:0]   idx_t;

    // Twiddle exponent for a lower-leg butterfly: (bfly mod (8 >> stage)) << stage.
    function automatic idx_t tw_addr_f(input stage_t stage, input idx_t bfly);
        idx_t mask;
        mask = idx_t'(N_BFLY - 1) >> stage;
        return (bfly & mask) << stage;
    endfunction

endpackage

// File: rtl/twiddle_addr_gen.sv
// Stage/butterfly counters that sequence the twiddle ROM address for one frame.
module twiddle_addr_gen
    import fft_radix2_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               accept,
    output logic [STAGE_W-1:0] stage_o,
    output logic [IDX_W-1:0]   bfly_o,
    output logic [IDX_W-1:0]   tw_addr_o,
    output logic               last_o
);

    stage_t stage_q, stage_d;
    idx_t   bfly_q,  bfly_d;

    always_comb begin
        stage_d = stage_q;
        bfly_d  = bfly_q;
        if (clear) begin
            stage_d = '0;
            bfly_d  = '0;
        end else if (accept) begin
            bfly_d = bfly_q + idx_t'(1);
            if (bfly_q == idx_t'(N_BFLY - 1)) begin
                stage_d = stage_q + stage_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            bfly_q  <= '0;
        end else begin
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
        end
    end

    assign stage_o   = stage_q;
    assign bfly_o    = bfly_q;
    assign tw_addr_o = tw_addr_f(stage_q, bfly_q);
    assign last_o    = (stage_q == stage_t'(LOG2N - 1)) && (bfly_q == idx_t'(N_BFLY - 1));

endmodule

// File: rtl/twiddle_mult_radix2.sv
// Three-stage complex twiddle multiplier with Q15 round-half-up and saturation.
module twiddle_mult_radix2
    import fft_radix2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_re,
    input  logic signed [WIDTH-1:0] s_im,
    output logic [IDX_W-1:0]        tw_addr,
    input  logic signed [WIDTH-1:0] tw_real,
    input  logic signed [WIDTH-1:0] tw_imag,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] m_re,
    output logic signed [WIDTH-1:0] m_im,
    output logic [STAGE_W-1:0]      m_stage,
    output logic [IDX_W-1:0]        m_idx,
    output logic                    m_last
);

    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW:0] RND     = {{(WIDTH+2){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};
    localparam logic signed [PW:0] SAT_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;

    logic en, accept;
    logic [STAGE_W-1:0] cnt_stage;
    logic [IDX_W-1:0]   cnt_bfly;
    logic               cnt_last;

    logic                    v1_q, v2_q, v3_q;
    logic signed [WIDTH-1:0] ar_q, ai_q, wr_q, wi_q;
    stage_t                  st1_q, st2_q, st3_q;
    idx_t                    ix1_q, ix2_q, ix3_q;
    logic                    ls1_q, ls2_q, ls3_q;
    logic signed [PW-1:0]    p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [WIDTH-1:0] re3_q, im3_q;

    logic signed [PW:0]      re_full, im_full, re_rnd, im_rnd;
    logic signed [WIDTH-1:0] re_sat, im_sat;

    // A single enable stalls every stage together so nothing is dropped or duplicated.
    assign en      = !v3_q || m_ready;
    assign s_ready = en;
    assign accept  = s_valid && en && !clear;

    twiddle_addr_gen u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .accept    (accept),
        .stage_o   (cnt_stage),
        .bfly_o    (cnt_bfly),
        .tw_addr_o (tw_addr),
        .last_o    (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
            ar_q <= '0; ai_q <= '0; wr_q <= '0; wi_q <= '0;
            st1_q <= '0; ix1_q <= '0; ls1_q <= 1'b0;
            p_rr_q <= '0; p_ii_q <= '0; p_ri_q <= '0; p_ir_q <= '0;
            st2_q <= '0; ix2_q <= '0; ls2_q <= 1'b0;
            re3_q <= '0; im3_q <= '0;
            st3_q <= '0; ix3_q <= '0; ls3_q <= 1'b0;
        end else begin
            if (clear) begin
                v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
            end else if (en) begin
                v1_q <= s_valid;
                v2_q <= v1_q;
                v3_q <= v2_q;
            end
            if (accept) begin
                ar_q  <= s_re;    ai_q  <= s_im;
                wr_q  <= tw_real; wi_q  <= tw_imag;
                st1_q <= cnt_stage; ix1_q <= cnt_bfly; ls1_q <= cnt_last;
            end
            if (en && v1_q) begin
                p_rr_q <= ar_q * wr_q;
                p_ii_q <= ai_q * wi_q;
                p_ri_q <= ar_q * wi_q;
                p_ir_q <= ai_q * wr_q;
                st2_q  <= st1_q; ix2_q <= ix1_q; ls2_q <= ls1_q;
            end
            if (en && v2_q) begin
                re3_q <= re_sat; im3_q <= im_sat;
                st3_q <= st2_q;  ix3_q <= ix2_q; ls3_q <= ls2_q;
            end
        end
    end

    always_comb begin
        re_full = {p_rr_q[PW-1], p_rr_q} - {p_ii_q[PW-1], p_ii_q};
        im_full = {p_ri_q[PW-1], p_ri_q} + {p_ir_q[PW-1], p_ir_q};
        re_rnd  = (re_full + RND) >>> (WIDTH - 1);
        im_rnd  = (im_full + RND) >>> (WIDTH - 1);
        re_sat  = re_rnd[WIDTH-1:0];
        im_sat  = im_rnd[WIDTH-1:0];
        if (re_rnd > SAT_MAX)      re_sat = SAT_MAX[WIDTH-1:0];
        else if (re_rnd < SAT_MIN) re_sat = SAT_MIN[WIDTH-1:0];
        if (im_rnd > SAT_MAX)      im_sat = SAT_MAX[WIDTH-1:0];
        else if (im_rnd < SAT_MIN) im_sat = SAT_MIN[WIDTH-1:0];
    end

    assign m_valid = v3_q;
    assign m_re    = re3_q;
    assign m_im    = im3_q;
    assign m_stage = st3_q;
    assign m_idx   = ix3_q;
    assign m_last  = ls3_q;

endmodule

// File: tb/tb_twiddle_mult_radix2.sv
// Randomized bench for twiddle_mult_radix2 against an arithmetic reference model.
module tb_twiddle_mult_radix2;

    localparam int TW_RE [8] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
    localparam int TW_IM [8] = '{0, -12540, -23170, -30274, -32767, -30274, -23170, -12540};
    localparam int SWEEP_ADDR [32] = '{0,1,2,3,4,5,6,7, 0,2,4,6,0,2,4,6,
                                        0,4,0,4,0,4,0,4, 0,0,0,0,0,0,0,0};

    logic clk = 1'b0;
    logic rst_n, clear, s_valid, s_ready, m_valid, m_last;
    logic m_ready = 1'b1;
    logic signed [15:0] s_re, s_im, tw_real, tw_imag, m_re, m_im;
    logic [2:0] tw_addr, m_idx;
    logic [1:0] m_stage;

    typedef struct {
        longint re, im;
        int     stage, idx, last, cyc;
    } item_t;

    item_t  exp_q[$];
    item_t  got_q[$];
    int     addr_log[$];
    int     checks = 0, errors = 0;
    int     cyc = 0, model_n = 0;
    bit     rand_ready = 1'b0, lat_check = 1'b1;
    bit     stalled = 1'b0;
    longint h_re, h_im;
    int     h_stage, h_idx, h_last;

    twiddle_mult_radix2 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .tw_addr(tw_addr), .tw_real(tw_real), .tw_imag(tw_imag),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
        .m_stage(m_stage), .m_idx(m_idx), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always_comb begin
        tw_real = 16'(TW_RE[tw_addr]);
        tw_imag = 16'(TW_IM[tw_addr]);
    end

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint q15_round_sat(input longint x);
        longint y;
        y = (x + 16384) >>> 15;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    // Scoreboard: outputs are retired before the accept of the same cycle is modelled.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_n = 0;
            stalled = 1'b0;
        end else begin
            item_t e, g;
            check_eq("s_ready_rule", s_ready, (!m_valid || m_ready));
            if (stalled) begin
                check_eq("stall_valid", m_valid, 1);
                check_eq("stall_re", m_re, h_re);
                check_eq("stall_im", m_im, h_im);
                check_eq("stall_tag", {m_stage, m_idx, m_last}, {h_stage[1:0], h_idx[2:0], h_last[0]});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("m_re", m_re, e.re);
                    check_eq("m_im", m_im, e.im);
                    check_eq("m_stage", m_stage, e.stage);
                    check_eq("m_idx", m_idx, e.idx);
                    check_eq("m_last", m_last, e.last);
                    if (lat_check) check_eq("latency", cyc - e.cyc, 3);
                end
                g.re = m_re; g.im = m_im; g.stage = m_stage; g.idx = m_idx;
                g.last = m_last; g.cyc = cyc;
                got_q.push_back(g);
            end
            stalled = m_valid && !m_ready && !clear;
            h_re = m_re; h_im = m_im; h_stage = m_stage; h_idx = m_idx; h_last = m_last;
            if (clear) begin
                exp_q.delete();
                model_n = 0;
            end else if (s_valid && s_ready) begin
                int st, ix, a;
                st = model_n / 8;
                ix = model_n % 8;
                a  = (ix % (8 >> st)) * (1 << st);
                check_eq("tw_addr", tw_addr, a);
                addr_log.push_back(tw_addr);
                e.re    = q15_round_sat(longint'(s_re) * TW_RE[a] - longint'(s_im) * TW_IM[a]);
                e.im    = q15_round_sat(longint'(s_re) * TW_IM[a] + longint'(s_im) * TW_RE[a]);
                e.stage = st;
                e.idx   = ix;
                e.last  = (model_n == 31) ? 1 : 0;
                e.cyc   = cyc;
                exp_q.push_back(e);
                model_n = (model_n + 1) % 32;
            end
        end
    end

    task automatic send(input logic signed [15:0] re, input logic signed [15:0] im);
        int unsigned guard = 0;
        s_valid = 1'b1;
        s_re    = re;
        s_im    = im;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            guard++;
            if (guard > 500) begin
                check_eq("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk); n++;
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    logic signed [15:0] stim_re [64];
    logic signed [15:0] stim_im [64];

    initial begin
        int base_a, base_b;
        rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_tw_addr", tw_addr, 0);
        check_eq("rst_m_re", m_re, 0);
        check_eq("rst_m_last", m_last, 0);
        @(posedge clk); #1;

        // Directed samples at fixed twiddles, then the rest of the 33-sample sweep.
        send(16'sd16384, 16'sd0);
        send(16'($urandom), 16'($urandom));
        send(-16'sd32768, -16'sd32768);
        send(16'($urandom), 16'($urandom));
        send(16'sd32767, 16'sd0);
        for (int i = 5; i < 33; i++) send(16'($urandom), 16'($urandom));
        drain();
        check_eq("unity_re", got_q[0].re, 16384);
        check_eq("unity_im", got_q[0].im, 0);
        check_eq("sat_re", got_q[2].re, -32768);
        check_eq("sat_im", got_q[2].im, 0);
        check_eq("round_re", got_q[4].re, 0);
        check_eq("round_im", got_q[4].im, -32766);
        for (int i = 0; i < 32; i++) check_eq("sweep_addr", addr_log[i], SWEEP_ADDR[i]);
        for (int i = 0; i < 31; i++) check_eq("sweep_nolast", got_q[i].last, 0);
        check_eq("sweep_last32", got_q[31].last, 1);
        check_eq("wrap_stage", got_q[32].stage, 0);
        check_eq("wrap_idx", got_q[32].idx, 0);
        check_eq("wrap_last", got_q[32].last, 0);

        // Same 64 samples with and without backpressure.
        for (int i = 0; i < 64; i++) begin
            stim_re[i] = 16'($urandom);
            stim_im[i] = 16'($urandom);
        end
        pulse_clear();
        base_a = got_q.size();
        for (int i = 0; i < 64; i++) send(stim_re[i], stim_im[i]);
        drain();
        pulse_clear();
        rand_ready = 1'b1; lat_check = 1'b0;
        base_b = got_q.size();
        for (int i = 0; i < 64; i++) send(stim_re[i], stim_im[i]);
        drain();
        rand_ready = 1'b0;
        @(posedge clk); #1;
        check_eq("bp_count", got_q.size() - base_b, 64);
        for (int i = 0; i < 64; i++) begin
            check_eq("bp_re", got_q[base_b+i].re, got_q[base_a+i].re);
            check_eq("bp_im", got_q[base_b+i].im, got_q[base_a+i].im);
            check_eq("bp_tag", got_q[base_b+i].idx + 8*got_q[base_b+i].stage,
                     got_q[base_a+i].idx + 8*got_q[base_a+i].stage);
        end
        lat_check = 1'b1;

        // Clear mid-frame, overriding a simultaneous accept.
        pulse_clear();
        for (int i = 0; i < 5; i++) send(16'($urandom), 16'($urandom));
        s_valid = 1'b1; s_re = 16'sd1234; s_im = 16'sd4321; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check_eq("clr_m_valid", m_valid, 0);
        check_eq("clr_tw_addr", tw_addr, 0);
        @(posedge clk); #1;
        send(16'sd1000, 16'sd2000);
        drain();
        check_eq("clr_next_stage", got_q[got_q.size()-1].stage, 0);
        check_eq("clr_next_idx", got_q[got_q.size()-1].idx, 0);

        // Asynchronous reset with the pipeline full.
        s_valid = 1'b1; s_re = 16'sd7000; s_im = -16'sd9000;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_m_valid", m_valid, 0);
        check_eq("arst_m_re", m_re, 0);
        check_eq("arst_m_im", m_im, 0);
        check_eq("arst_m_stage", m_stage, 0);
        check_eq("arst_m_idx", m_idx, 0);
        check_eq("arst_m_last", m_last, 0);
        check_eq("arst_tw_addr", tw_addr, 0);
        check_eq("arst_s_ready", s_ready, 1);
        s_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'sd16384, 16'sd16384);
        drain();
        check_eq("post_rst_re", got_q[got_q.size()-1].re, 16384);
        check_eq("post_rst_im", got_q[got_q.size()-1].im, 16384);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
